// File: rtl/cpu_run_ctrl.sv
// Run/halt/single-step sequencer for the 16-bit single-cycle core.
// Generates the datapath clock enable and reset, and counts enabled cycles.
module cpu_run_ctrl #(
  parameter int unsigned DIV_COUNT = 1,
  parameter bit          AUTO_RUN  = 1'b1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             clk_pi,
  input  logic             reset_pi,
  input  logic             run_req_pi,
  input  logic             step_req_pi,
  input  logic             halt_req_pi,
  input  logic             halt_cmd_pi,
  input  logic             rst_cmd_pi,
  output logic             cpu_clk_en_po,
  output logic             cpu_reset_po,
  output logic             halted_po,
  output logic [CNT_W-1:0] cycle_count_po
);

  localparam int unsigned DIV_W = (DIV_COUNT > 1) ? $clog2(DIV_COUNT) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_STEP   = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  localparam state_e RESET_STATE = AUTO_RUN ? ST_RUN : ST_HALTED;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             skip_q, skip_d;
  logic             run_prev_q, run_prev_d;
  logic             step_prev_q, step_prev_d;
  logic             halt_prev_q, halt_prev_d;
  logic [CNT_W-1:0] cycle_count_q, cycle_count_d;

  logic tick_s;
  logic run_req_s;
  logic step_req_s;
  logic halt_req_s;
  logic active_s;
  logic clk_en_s;

  // State register; prev registers reset to 1 so a button held through reset is not a request.
  always_ff @(posedge clk_pi) begin
    if (reset_pi) begin
      state_q       <= RESET_STATE;
      div_cnt_q     <= '0;
      skip_q        <= 1'b0;
      run_prev_q    <= 1'b1;
      step_prev_q   <= 1'b1;
      halt_prev_q   <= 1'b1;
      cycle_count_q <= '0;
    end else begin
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      skip_q        <= skip_d;
      run_prev_q    <= run_prev_d;
      step_prev_q   <= step_prev_d;
      halt_prev_q   <= halt_prev_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  // Tick, edge detection, enable generation and next-state selection.
  always_comb begin
    tick_s    = (div_cnt_q == DIV_LAST) & ~reset_pi;
    div_cnt_d = (div_cnt_q == DIV_LAST) ? '0 : div_cnt_q + DIV_W'(1);

    run_req_s   = run_req_pi  & ~run_prev_q;
    step_req_s  = step_req_pi & ~step_prev_q;
    halt_req_s  = halt_req_pi & ~halt_prev_q;
    run_prev_d  = run_req_pi;
    step_prev_d = step_req_pi;
    halt_prev_d = halt_req_pi;

    active_s = (state_q == ST_RUN) | (state_q == ST_STEP);
    // skip lets a resume execute past the HALT instruction it stopped on.
    clk_en_s = tick_s & active_s & (~halt_cmd_pi | skip_q);

    state_d = state_q;
    if (halt_req_s) begin
      state_d = ST_HALTED;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (tick_s & halt_cmd_pi & ~skip_q) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_STEP: begin
          if (tick_s) begin
            state_d = ST_HALTED;
          end else begin
            state_d = ST_STEP;
          end
        end
        ST_HALTED: begin
          if (step_req_s) begin
            state_d = ST_STEP;
          end else if (run_req_s) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_HALTED;
          end
        end
        default: begin
          state_d = ST_HALTED;
        end
      endcase
    end

    if ((state_q == ST_HALTED) & (state_d != ST_HALTED)) begin
      skip_d = 1'b1;
    end else if (clk_en_s) begin
      skip_d = 1'b0;
    end else begin
      skip_d = skip_q;
    end

    if (clk_en_s) begin
      cycle_count_d = cycle_count_q + CNT_W'(1);
    end else begin
      cycle_count_d = cycle_count_q;
    end
  end

  assign cpu_clk_en_po  = clk_en_s;
  assign cpu_reset_po   = reset_pi | (clk_en_s & rst_cmd_pi);
  assign halted_po      = (state_q == ST_HALTED);
  assign cycle_count_po = cycle_count_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: three instances (DIV1/RUN, DIV4/RUN, DIV1/HALTED) checked every
// cycle against a behavioural model, plus directed literal checks from the test plan.
module tb_cpu_run_ctrl;

  localparam int DIVS  [3] = '{1, 4, 1};
  localparam int AUTOS [3] = '{1, 1, 0};
  localparam int M_RUN = 0, M_STEP = 1, M_HALT = 2;

  logic        clk;
  logic        rst;
  logic        run_i  [3];
  logic        step_i [3];
  logic        halt_i [3];
  logic        hc_i   [3];
  logic        rc_i   [3];
  logic        en_o   [3];
  logic        rs_o   [3];
  logic        hl_o   [3];
  logic [31:0] cnt_o  [3];

  int n_pass  = 0;
  int n_total = 0;

  // Behavioural model state: mode, skip, previous button levels, enabled count, cycles since reset.
  int          mst    [3];
  bit          mskip  [3];
  bit          mp_run [3];
  bit          mp_step[3];
  bit          mp_halt[3];
  logic [31:0] mcnt   [3];
  int          mk     [3];
  bit          mvalid [3] = '{0, 0, 0};

  cpu_run_ctrl #(.DIV_COUNT(1), .AUTO_RUN(1'b1), .CNT_W(32)) dut_a (
    .clk_pi(clk), .reset_pi(rst), .run_req_pi(run_i[0]), .step_req_pi(step_i[0]),
    .halt_req_pi(halt_i[0]), .halt_cmd_pi(hc_i[0]), .rst_cmd_pi(rc_i[0]),
    .cpu_clk_en_po(en_o[0]), .cpu_reset_po(rs_o[0]), .halted_po(hl_o[0]),
    .cycle_count_po(cnt_o[0]));

  cpu_run_ctrl #(.DIV_COUNT(4), .AUTO_RUN(1'b1), .CNT_W(32)) dut_b (
    .clk_pi(clk), .reset_pi(rst), .run_req_pi(run_i[1]), .step_req_pi(step_i[1]),
    .halt_req_pi(halt_i[1]), .halt_cmd_pi(hc_i[1]), .rst_cmd_pi(rc_i[1]),
    .cpu_clk_en_po(en_o[1]), .cpu_reset_po(rs_o[1]), .halted_po(hl_o[1]),
    .cycle_count_po(cnt_o[1]));

  cpu_run_ctrl #(.DIV_COUNT(1), .AUTO_RUN(1'b0), .CNT_W(32)) dut_c (
    .clk_pi(clk), .reset_pi(rst), .run_req_pi(run_i[2]), .step_req_pi(step_i[2]),
    .halt_req_pi(halt_i[2]), .halt_cmd_pi(hc_i[2]), .rst_cmd_pi(rc_i[2]),
    .cpu_clk_en_po(en_o[2]), .cpu_reset_po(rs_o[2]), .halted_po(hl_o[2]),
    .cycle_count_po(cnt_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // Compare every instance against the model at the falling edge, then advance the model.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      bit tk, act, en_e, rs_e, e_run, e_step, e_halt;
      int nst;
      tk   = !rst && ((mk[i] % DIVS[i]) == DIVS[i] - 1);
      act  = (mst[i] == M_RUN) || (mst[i] == M_STEP);
      en_e = tk && act && (!hc_i[i] || mskip[i]);
      rs_e = rst || (en_e && rc_i[i]);
      chk($sformatf("en[%0d]", i), {31'd0, en_o[i]}, {31'd0, en_e});
      chk($sformatf("cpu_reset[%0d]", i), {31'd0, rs_o[i]}, {31'd0, rs_e});
      if (mvalid[i]) begin
        chk($sformatf("halted[%0d]", i), {31'd0, hl_o[i]}, {31'd0, mst[i] == M_HALT});
        chk($sformatf("count[%0d]", i), cnt_o[i], mcnt[i]);
      end
      if (rst) begin
        mst[i]     = (AUTOS[i] != 0) ? M_RUN : M_HALT;
        mskip[i]   = 1'b0;
        mp_run[i]  = 1'b1;
        mp_step[i] = 1'b1;
        mp_halt[i] = 1'b1;
        mcnt[i]    = 32'd0;
        mk[i]      = 0;
        mvalid[i]  = 1'b1;
      end else begin
        e_run  = run_i[i]  && !mp_run[i];
        e_step = step_i[i] && !mp_step[i];
        e_halt = halt_i[i] && !mp_halt[i];
        nst = mst[i];
        if (e_halt) nst = M_HALT;
        else if (mst[i] == M_RUN && tk && hc_i[i] && !mskip[i]) nst = M_HALT;
        else if (mst[i] == M_STEP && tk) nst = M_HALT;
        else if (mst[i] == M_HALT && e_step) nst = M_STEP;
        else if (mst[i] == M_HALT && e_run) nst = M_RUN;
        if (mst[i] == M_HALT && nst != M_HALT) mskip[i] = 1'b1;
        else if (en_e) mskip[i] = 1'b0;
        mst[i]     = nst;
        mcnt[i]    = mcnt[i] + (en_e ? 32'd1 : 32'd0);
        mk[i]      = mk[i] + 1;
        mp_run[i]  = run_i[i];
        mp_step[i] = step_i[i];
        mp_halt[i] = halt_i[i];
      end
    end
  end

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_i[i] = 1'b0; step_i[i] = 1'b0; halt_i[i] = 1'b0; hc_i[i] = 1'b0; rc_i[i] = 1'b0;
    end
    run_i[2] = 1'b1;

    // Free-run, divider and held-through-reset button.
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 13; c++) begin
      if (c == 2) run_i[2] = 1'b0;
      if (c == 4) run_i[2] = 1'b1;
      @(negedge clk);
      if (c == 0)  chk("a_first_en", {31'd0, en_o[0]}, 32'd1);
      if (c == 10) chk("a_count10", cnt_o[0], 32'd10);
      if (c == 10) chk("a_not_halted", {31'd0, hl_o[0]}, 32'd0);
      if (c == 2)  chk("b_no_en_c2", {31'd0, en_o[1]}, 32'd0);
      if (c == 3)  chk("b_en_c3", {31'd0, en_o[1]}, 32'd1);
      if (c == 11) chk("b_en_c11", {31'd0, en_o[1]}, 32'd1);
      if (c == 12) chk("b_count3", cnt_o[1], 32'd3);
      if (c == 4)  chk("c_held_halted", {31'd0, hl_o[2]}, 32'd1);
      if (c == 5)  chk("c_run_after_press", {31'd0, hl_o[2]}, 32'd0);
      next_cyc();
    end

    // Mid-operation reset, then HALT instruction at cycle 5.
    rst = 1'b1;
    @(negedge clk);
    chk("a_reset_no_en", {31'd0, en_o[0]}, 32'd0);
    chk("a_reset_out", {31'd0, rs_o[0]}, 32'd1);
    next_cyc();
    next_cyc();
    rst = 1'b0;
    for (int c = 0; c < 9; c++) begin
      if (c == 5) hc_i[0] = 1'b1;
      @(negedge clk);
      if (c == 5) chk("a_halt_no_en", {31'd0, en_o[0]}, 32'd0);
      if (c == 6) chk("a_halted_c6", {31'd0, hl_o[0]}, 32'd1);
      if (c == 8) chk("a_count5", cnt_o[0], 32'd5);
      next_cyc();
    end

    // Single steps past a held HALT instruction.
    for (int s = 0; s < 2; s++) begin
      step_i[0] = 1'b1;
      next_cyc();
      @(negedge clk);
      chk("a_step_pulse", {31'd0, en_o[0]}, 32'd1);
      next_cyc();
      @(negedge clk);
      chk("a_step_done_en", {31'd0, en_o[0]}, 32'd0);
      chk("a_step_halted", {31'd0, hl_o[0]}, 32'd1);
      chk("a_step_count", cnt_o[0], 32'd6 + 32'(s));
      step_i[0] = 1'b0;
      next_cyc();
    end

    // RST instruction during RUN.
    hc_i[0] = 1'b0;
    run_i[0] = 1'b1;
    next_cyc();
    next_cyc();
    rc_i[0] = 1'b1;
    @(negedge clk);
    chk("a_rst_cmd_reset", {31'd0, rs_o[0]}, 32'd1);
    next_cyc();
    rc_i[0] = 1'b0;
    @(negedge clk);
    chk("a_rst_cmd_once", {31'd0, rs_o[0]}, 32'd0);
    chk("a_rst_cmd_still_run", {31'd0, en_o[0]}, 32'd1);

    // halt and run together while HALTED.
    next_cyc();
    halt_i[0] = 1'b1;
    next_cyc();
    halt_i[0] = 1'b0;
    run_i[0] = 1'b0;
    next_cyc();
    next_cyc();
    halt_i[0] = 1'b1;
    run_i[0] = 1'b1;
    next_cyc();
    next_cyc();
    @(negedge clk);
    chk("a_halt_beats_run", {31'd0, hl_o[0]}, 32'd1);

    // step and run together: one pulse then HALTED.
    next_cyc();
    halt_i[0] = 1'b0;
    run_i[0] = 1'b0;
    next_cyc();
    step_i[0] = 1'b1;
    run_i[0] = 1'b1;
    next_cyc();
    @(negedge clk);
    chk("a_step_run_pulse", {31'd0, en_o[0]}, 32'd1);
    next_cyc();
    @(negedge clk);
    chk("a_step_run_halted", {31'd0, hl_o[0]}, 32'd1);
    next_cyc();

    // Randomized traffic on all three instances with occasional resets.
    for (int c = 0; c < 4000; c++) begin
      rst = ($urandom_range(0, 249) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 5) == 0)  run_i[i]  = ~run_i[i];
        if ($urandom_range(0, 7) == 0)  step_i[i] = ~step_i[i];
        if ($urandom_range(0, 11) == 0) halt_i[i] = ~halt_i[i];
        hc_i[i] = ($urandom_range(0, 3) == 0);
        rc_i[i] = ($urandom_range(0, 4) == 0);
      end
      next_cyc();
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
